// File: rtl/axi_image_loader.sv
// AXI4-Lite write-side slave holding a 256-pixel image buffer, and a scanner
// that streams the non-zero pixels to the SNN core as (index, value) events.
module axi_image_loader #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int NUM_PIXELS     = 256
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]     AWADDR,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    output logic                          PIX_VALID,
    input  logic                          PIX_READY,
    output logic [7:0]                    PIX_ADDR,
    output logic [7:0]                    PIX_VAL,
    output logic                          BUSY,
    output logic                          IMG_DONE
);

    localparam int         WA_W      = AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;
    localparam logic [7:0] LAST_IDX  = 8'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} s_state_e;

    w_state_e    w_state_q, w_state_d;
    s_state_e    s_state_q, s_state_d;
    logic        axready_q, axready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [7:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        pix_valid_q, pix_valid_d;
    logic [7:0]  pix_addr_q, pix_addr_d;
    logic [7:0]  pix_val_q, pix_val_d;
    logic        img_done_q, img_done_d;
    logic [7:0]  mem_q [NUM_PIXELS];
    logic [7:0]  mem_d [NUM_PIXELS];

    logic [WA_W-1:0] word_addr;
    logic            is_pix;
    logic            is_ctrl;
    logic            start_req;
    logic            unused_bits;

    assign word_addr   = AWADDR[AXI_ADDR_WIDTH-1:2];
    assign is_pix      = word_addr < WA_W'(NUM_PIXELS);
    assign is_ctrl     = word_addr == WA_W'(12'h400 >> 2);
    assign unused_bits = ^{AWADDR[1:0], WDATA[AXI_DATA_WIDTH-1:8], WSTRB[AXI_DATA_WIDTH/8-1:1]};

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
        w_state_d   = w_state_q;
        s_state_d   = s_state_q;
        axready_d   = axready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        pix_valid_d = pix_valid_q;
        pix_addr_d  = pix_addr_q;
        pix_val_d   = pix_val_q;
        img_done_d  = 1'b0;
        mem_d       = mem_q;
        start_req   = 1'b0;

        // AW and W are only ever accepted together, one write in flight.
        unique case (w_state_q)
            W_IDLE: begin
                if (AWVALID && WVALID) begin
                    w_state_d = W_ACK;
                    axready_d = 1'b1;
                end
            end
            W_ACK: begin
                axready_d = 1'b0;
                bvalid_d  = 1'b1;
                w_state_d = W_RESP;
                if (is_pix) begin
                    if (busy_q) begin
                        bresp_d = RESP_SLV;
                    end else begin
                        bresp_d = RESP_OKAY;
                        if (WSTRB[0]) mem_d[word_addr[7:0]] = WDATA[7:0];
                    end
                end else if (is_ctrl) begin
                    if (WDATA[0] && busy_q) begin
                        bresp_d = RESP_SLV;
                    end else begin
                        bresp_d   = RESP_OKAY;
                        start_req = WDATA[0];
                    end
                end else begin
                    bresp_d = RESP_SLV;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        // BUSY stays high through S_DONE, so a START landing there is rejected above.
        unique case (s_state_q)
            S_IDLE: begin
                if (start_req) begin
                    s_state_d = S_SCAN;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                end
            end
            S_SCAN: begin
                if (mem_q[idx_q] != 8'd0) begin
                    s_state_d   = S_EMIT;
                    pix_valid_d = 1'b1;
                    pix_addr_d  = idx_q;
                    pix_val_d   = mem_q[idx_q];
                end else if (idx_q == LAST_IDX) begin
                    s_state_d  = S_DONE;
                    img_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            S_EMIT: begin
                if (PIX_READY) begin
                    pix_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        s_state_d  = S_DONE;
                        img_done_d = 1'b1;
                    end else begin
                        s_state_d = S_SCAN;
                        idx_d     = idx_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                busy_d    = 1'b0;
                s_state_d = S_IDLE;
            end
            default: s_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!ARESETN) begin
            w_state_q   <= W_IDLE;
            s_state_q   <= S_IDLE;
            axready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_addr_q  <= '0;
            pix_val_q   <= '0;
            img_done_q  <= 1'b0;
            // NOTE: the image buffer is deliberately reset, so it must be flops rather than a RAM macro.
            mem_q       <= '{default: '0};
        end else begin
            w_state_q   <= w_state_d;
            s_state_q   <= s_state_d;
            axready_q   <= axready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            pix_valid_q <= pix_valid_d;
            pix_addr_q  <= pix_addr_d;
            pix_val_q   <= pix_val_d;
            img_done_q  <= img_done_d;
            mem_q       <= mem_d;
        end
    end

    assign AWREADY   = axready_q;
    assign WREADY    = axready_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign PIX_VALID = pix_valid_q;
    assign PIX_ADDR  = pix_addr_q;
    assign PIX_VAL   = pix_val_q;
    assign BUSY      = busy_q;
    assign IMG_DONE  = img_done_q;

endmodule

// File: tb/tb_axi_image_loader.sv
// Directed and randomized bench for axi_image_loader; expectations come from
// a pixel-array model and the address-map rules, compared with assertions.
module tb_axi_image_loader;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [11:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        PIX_VALID;
    logic        PIX_READY;
    logic [7:0]  PIX_ADDR;
    logic [7:0]  PIX_VAL;
    logic        BUSY;
    logic        IMG_DONE;

    axi_image_loader dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .PIX_ADDR(PIX_ADDR), .PIX_VAL(PIX_VAL),
        .BUSY(BUSY), .IMG_DONE(IMG_DONE)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the image as a plain array, plus whether a stream is running.
    logic [7:0]  model_mem [256];
    bit          model_busy;
    int          accept_cyc;
    int          done_ofs;
    logic [15:0] got_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (model_mem[i]) model_mem[i] = 8'd0;
        model_busy = 1'b0;
    endtask

    task automatic model_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output bit start);
        int word;
        word  = int'(addr) / 4;
        start = 1'b0;
        if (word < 256) begin
            if (model_busy) resp = 2'b10;
            else begin
                resp = 2'b00;
                if (strb[0]) model_mem[word] = data[7:0];
            end
        end else if (word == 256) begin
            if (data[0] && model_busy) resp = 2'b10;
            else begin
                resp  = 2'b00;
                start = data[0];
            end
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input string tag);
        logic [1:0] exp_resp;
        bit         start;
        int         n;
        model_write(addr, data, strb, exp_resp, start);
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!AWREADY && n < 20);
        if (!AWREADY) check({tag, "_awready_timeout"}, 32'd0, 32'd1);
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        if (start) begin
            model_busy = 1'b1;
            accept_cyc = cyc;
        end
        check({tag, "_bvalid"}, 32'(BVALID), 32'd1);
        check({tag, "_bresp"}, 32'(BRESP), 32'(exp_resp));
        @(negedge ACLK);
    endtask

    // Collects events until IMG_DONE plus two cycles, then compares with the model's image.
    task automatic collect(input bit rnd_ready, input string tag);
        logic [15:0] exp_q [$];
        int done_n, done_cyc, n, post;
        done_n = 0; done_cyc = -1; n = 0; post = 0;
        got_q.delete();
        while (n < 4000 && post < 3) begin
            PIX_READY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (PIX_VALID && PIX_READY) got_q.push_back({PIX_ADDR, PIX_VAL});
            if (IMG_DONE) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_n > 0) post++;
            @(negedge ACLK);
            n++;
        end
        PIX_READY = 1'b1;
        model_busy = 1'b0;
        done_ofs = done_cyc - accept_cyc;
        for (int i = 0; i < 256; i++)
            if (model_mem[i] != 8'd0) exp_q.push_back({8'(i), model_mem[i]});
        check({tag, "_done_pulses"}, 32'(done_n), 32'd1);
        check({tag, "_busy_after"}, 32'(BUSY), 32'd0);
        check({tag, "_evt_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_evt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [1:0] exp_resp;
        bit         start;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;

        model_clear();
        PIX_READY = 1'b0; BREADY = 1'b0;

        // Reset held with a START write presented on the bus.
        ARESETN = 1'b0; AWADDR = 12'h400; WDATA = 32'd1; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        repeat (2) @(negedge ACLK);
        check("rst_awready", 32'(AWREADY), 32'd0);
        check("rst_wready", 32'(WREADY), 32'd0);
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_bresp", 32'(BRESP), 32'd0);
        check("rst_pix_valid", 32'(PIX_VALID), 32'd0);
        check("rst_pix_addr", 32'(PIX_ADDR), 32'd0);
        check("rst_pix_val", 32'(PIX_VAL), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_img_done", 32'(IMG_DONE), 32'd0);
        AWVALID = 1'b0; WVALID = 1'b0;
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Empty image: no events, IMG_DONE in the 257th cycle after the accepting edge.
        axi_write(12'h400, 32'd1, 4'hF, "start_empty");
        collect(1'b0, "empty");
        check("empty_done_latency", 32'(done_ofs), 32'd256);

        // Two pixels, full-rate consumer.
        axi_write(12'h014, 32'h80, 4'hF, "wr_p5");
        axi_write(12'h320, 32'h11, 4'hF, "wr_p200");
        axi_write(12'h400, 32'd1, 4'hF, "start_two");
        collect(1'b0, "two");

        // Re-stream the same image with the consumer stalled on the first event.
        PIX_READY = 1'b0;
        axi_write(12'h400, 32'd1, 4'hF, "start_stall");
        n = 0;
        while (!PIX_VALID && n < 400) begin
            @(negedge ACLK);
            n++;
        end
        check("stall_valid_seen", 32'(PIX_VALID), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall_valid_c%0d", i), 32'(PIX_VALID), 32'd1);
            check($sformatf("stall_addr_c%0d", i), 32'(PIX_ADDR), 32'h05);
            check($sformatf("stall_val_c%0d", i), 32'(PIX_VAL), 32'h80);
            @(negedge ACLK);
        end
        axi_write(12'h010, 32'h55, 4'hF, "busy_pix_write");
        axi_write(12'h400, 32'd1, 4'hF, "busy_start");
        check("busy_still_high", 32'(BUSY), 32'd1);
        check("busy_addr_held", 32'(PIX_ADDR), 32'h05);
        collect(1'b1, "stall");

        // Address-map corner cases while idle.
        axi_write(12'h800, 32'hAB, 4'hF, "bad_addr_800");
        axi_write(12'h404, 32'd1, 4'hF, "bad_addr_404");
        axi_write(12'h01C, 32'h77, 4'b1110, "no_strobe");
        axi_write(12'h400, 32'd0, 4'hF, "ctrl_noop");
        check("noop_busy", 32'(BUSY), 32'd0);

        // AWVALID leads WVALID by 3 cycles; BREADY held off for 4 cycles.
        model_write(12'h00C, 32'h33, 4'hF, exp_resp, start);
        AWADDR = 12'h00C; WDATA = 32'h33; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b0; BREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check($sformatf("aw_only_ready_c%0d", i), 32'({AWREADY, WREADY}), 32'd0);
        end
        WVALID = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!AWREADY && n < 20);
        check("late_w_both_ready", 32'({AWREADY, WREADY}), 32'b11);
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bhold_bvalid_c%0d", i), 32'(BVALID), 32'd1);
            check($sformatf("bhold_bresp_c%0d", i), 32'(BRESP), 32'(exp_resp));
            check($sformatf("bhold_noready_c%0d", i), 32'({AWREADY, WREADY}), 32'd0);
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        check("bhold_released", 32'(BVALID), 32'd0);

        // Random image including both ends of the buffer, random backpressure.
        for (int i = 0; i < 24; i++) begin
            a = 12'($urandom_range(0, 255)) << 2;
            d = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
            d = d | ({$urandom} & 32'hFFFF_FF00);
            s = {3'($urandom), ($urandom_range(0, 4) != 0)};
            axi_write(a, d, s, $sformatf("rnd_wr%0d", i));
        end
        axi_write(12'h000, 32'($urandom_range(1, 255)), 4'hF, "wr_p0");
        axi_write(12'h3FC, 32'($urandom_range(1, 255)), 4'hF, "wr_p255");
        axi_write(12'h400, 32'd1, 4'hF, "start_rnd");
        collect(1'b1, "rnd");

        // Reset after the first event: stream aborts and the buffer is cleared.
        PIX_READY = 1'b1;
        axi_write(12'h400, 32'd1, 4'hF, "start_abort");
        n = 0;
        while (!(PIX_VALID && PIX_READY) && n < 400) begin
            @(negedge ACLK);
            n++;
        end
        check("abort_first_event", 32'(PIX_VALID), 32'd1);
        @(negedge ACLK);
        ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        model_clear();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (IMG_DONE || BUSY || PIX_VALID) n++;
            @(negedge ACLK);
        end
        check("abort_quiet", 32'(n), 32'd0);
        axi_write(12'h400, 32'd1, 4'hF, "start_post_rst");
        collect(1'b0, "post_rst");
        check("post_rst_done_latency", 32'(done_ofs), 32'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
